// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with alias table, multi-port commit and checkpointed recovery
// Ports: clk/rst/rdy/flush control; rd_idx -> rd_q/rd_v operand reads with commit bypass;
// ren_* rename request; cm_* commit ports (higher index younger);
// ck_save/ck_release/ck_restore/ck_restore_tag checkpoint FIFO control; ck_tag/ck_full status.
module rename_reg_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCM   = 2,
  parameter int NCKPT = 4,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [NRD*RW-1:0]     rd_idx,
  output logic [NRD*ROB_W-1:0]  rd_q,
  output logic [NRD*XLEN-1:0]   rd_v,
  input  logic                  ren_en,
  input  logic [RW-1:0]         ren_reg,
  input  logic [ROB_W-1:0]      ren_alias,
  input  logic [NCM-1:0]        cm_valid,
  input  logic [NCM*RW-1:0]     cm_reg,
  input  logic [NCM*ROB_W-1:0]  cm_alias,
  input  logic [NCM*XLEN-1:0]   cm_data,
  input  logic                  ck_save,
  output logic [CW-1:0]         ck_tag,
  output logic                  ck_full,
  input  logic                  ck_release,
  input  logic                  ck_restore,
  input  logic [CW-1:0]         ck_restore_tag
);
  localparam int NW = CW + 1;
  typedef logic [NREG-1:0][ROB_W-1:0] tbl_t;
  tbl_t alias_q, alias_d;
  tbl_t [NCKPT-1:0] ck_q, ck_d;
  logic [NREG-1:0][XLEN-1:0] reg_q, reg_d;
  logic [CW-1:0] head_q, head_d, tail_q, tail_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic rel, sv, rs;
  // Drop every entry that still names an id retiring this cycle.
  function automatic tbl_t clr(tbl_t t, logic [NCM-1:0] v, logic [NCM*RW-1:0] r, logic [NCM*ROB_W-1:0] a);
    clr = t;
    for (int p = 0; p < NCM; p++)
      if (v[p] && r[p*RW+:RW] != '0 && t[r[p*RW+:RW]] == a[p*ROB_W+:ROB_W]) clr[r[p*RW+:RW]] = '0;
  endfunction
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [RW-1:0] idx;
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0] v;
    assign idx = rd_idx[i*RW+:RW];
    always_comb begin
      q = alias_q[idx];
      v = reg_q[idx];
      for (int p = 0; p < NCM; p++)
        if (cm_valid[p] && cm_reg[p*RW+:RW] == idx && cm_alias[p*ROB_W+:ROB_W] == alias_q[idx]) begin
          q = '0;
          v = cm_data[p*XLEN+:XLEN];
        end
      if (idx == '0) begin
        q = '0;
        v = '0;
      end
    end
    assign rd_q[i*ROB_W+:ROB_W] = q;
    assign rd_v[i*XLEN+:XLEN]   = v;
  end
  assign ck_tag  = tail_q;
  assign ck_full = cnt_q == NW'(NCKPT);
  always_comb begin
    reg_d = reg_q;
    for (int p = 0; p < NCM; p++)
      if (cm_valid[p] && cm_reg[p*RW+:RW] != '0) reg_d[cm_reg[p*RW+:RW]] = cm_data[p*XLEN+:XLEN];
    for (int k = 0; k < NCKPT; k++) ck_d[k] = clr(ck_q[k], cm_valid, cm_reg, cm_alias);
    alias_d = clr(alias_q, cm_valid, cm_reg, cm_alias);
    rel = ck_release && cnt_q != '0;
    sv = ck_save && !ck_full;
    rs = ck_restore && ({1'b0, CW'(ck_restore_tag - head_q)} < cnt_q);
    head_d = head_q;
    tail_d = tail_q;
    cnt_d = cnt_q;
    if (flush) begin
      alias_d = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d = '0;
    end else if (rs) begin
      // Restoring the slot a same-cycle release frees leaves an empty FIFO anchored at that slot.
      alias_d = ck_d[ck_restore_tag];
      tail_d = ck_restore_tag;
      head_d = (ck_restore_tag == head_q) ? head_q : head_q + CW'(rel);
      cnt_d = {1'b0, CW'(ck_restore_tag - head_d)};
    end else begin
      if (ren_en && ren_reg != '0) alias_d[ren_reg] = ren_alias;
      if (sv) begin
        ck_d[tail_q] = alias_d;
        tail_d = tail_q + 1'b1;
      end
      head_d = head_q + CW'(rel);
      cnt_d = cnt_q + NW'(sv) - NW'(rel);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alias_q <= '0;
      ck_q <= '0;
      reg_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      alias_q <= alias_d;
      ck_q <= ck_d;
      reg_q <= reg_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed self-checking bench for rename_reg_file
module tb_rename_reg_file;
  logic clk, rst, rdy, flush;
  logic [9:0] rd_idx;
  logic [7:0] rd_q;
  logic [63:0] rd_v;
  logic ren_en;
  logic [4:0] ren_reg;
  logic [3:0] ren_alias;
  logic [1:0] cm_valid;
  logic [9:0] cm_reg;
  logic [7:0] cm_alias;
  logic [63:0] cm_data;
  logic ck_save, ck_full, ck_release, ck_restore;
  logic [1:0] ck_tag, ck_restore_tag;
  int checks = 0;
  int errors = 0;
  logic [3:0] q0, q1;
  logic [31:0] v0, v1;
  assign q0 = rd_q[3:0];
  assign q1 = rd_q[7:4];
  assign v0 = rd_v[31:0];
  assign v1 = rd_v[63:32];
  rename_reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rd_idx(rd_idx), .rd_q(rd_q), .rd_v(rd_v),
    .ren_en(ren_en), .ren_reg(ren_reg), .ren_alias(ren_alias),
    .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_alias(cm_alias), .cm_data(cm_data),
    .ck_save(ck_save), .ck_tag(ck_tag), .ck_full(ck_full),
    .ck_release(ck_release), .ck_restore(ck_restore), .ck_restore_tag(ck_restore_tag)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rdy = 1; flush = 0; ren_en = 0; ren_reg = 0; ren_alias = 0;
    cm_valid = 0; cm_reg = 0; cm_alias = 0; cm_data = 0;
    ck_save = 0; ck_release = 0; ck_restore = 0; ck_restore_tag = 0;
  endtask
  task automatic rd(int a, int b);
    rd_idx = {5'(b), 5'(a)};
  endtask
  task automatic ren(int r, int a);
    ren_en = 1; ren_reg = 5'(r); ren_alias = 4'(a);
  endtask
  task automatic cm(int p, int r, int a, logic [31:0] d);
    cm_valid[p] = 1'b1;
    cm_reg[p*5+:5] = 5'(r);
    cm_alias[p*4+:4] = 4'(a);
    cm_data[p*32+:32] = d;
  endtask
  task automatic restore(int t);
    ck_restore = 1; ck_restore_tag = 2'(t);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask
  initial begin
    clk = 0; rst = 1;
    idle();
    rd(5, 5);
    #12 rst = 0;
    #1;
    check("rst_q0", q0, 0);
    check("rst_v0", v0, 0);
    check("rst_q1", q1, 0);
    check("rst_v1", v1, 0);
    check("rst_tag", ck_tag, 0);
    check("rst_full", ck_full, 0);
    ren(5, 3); step();
    check("ren_q0", q0, 3);
    check("ren_q1", q1, 3);
    cm(0, 5, 3, 32'hDEAD); #1;
    check("byp_q", q0, 0);
    check("byp_v", v0, 32'hDEAD);
    step();
    check("cm_q", q0, 0);
    check("cm_v", v0, 32'hDEAD);
    ren(5, 3); step();
    ren(5, 7); step();
    cm(0, 5, 3, 32'h11); #1;
    check("nobyp_q", q0, 7);
    check("nobyp_v", v0, 32'hDEAD);
    step();
    check("young_q", q0, 7);
    check("young_v", v0, 32'h11);
    rd(6, 6); ren(6, 9); step();
    cm(0, 6, 9, 32'hA); cm(1, 6, 9, 32'hB); #1;
    check("dual_byp_q", q1, 0);
    check("dual_byp_v", v1, 32'hB);
    step();
    check("dual_q", q0, 0);
    check("dual_v", v0, 32'hB);
    rd(1, 1); ren(1, 2); step();
    check("tag_pre", ck_tag, 0);
    ck_save = 1; step();
    check("tag_post", ck_tag, 1);
    ren(1, 4); step();
    check("x1_q4", q0, 4);
    restore(0); step();
    check("rest_q", q0, 2);
    check("rest_tag", ck_tag, 0);
    check("rest_full", ck_full, 0);
    rd(2, 2); ren(2, 5); step();
    ck_save = 1; step();
    cm(0, 2, 5, 32'h77); step();
    restore(0); step();
    check("snapclr_q", q0, 0);
    check("snapclr_v", v0, 32'h77);
    check("snapclr_tag", ck_tag, 0);
    rd(7, 7);
    for (int k = 0; k < 4; k++) begin
      ck_save = 1; ren(7, 10 + k); step();
    end
    check("full4", ck_full, 1);
    check("full4_tag", ck_tag, 0);
    ck_save = 1; step();
    check("save5_full", ck_full, 1);
    check("save5_tag", ck_tag, 0);
    ck_release = 1; step();
    check("rel_full", ck_full, 0);
    check("rel_tag", ck_tag, 0);
    ck_save = 1; step();
    check("wrap_full", ck_full, 1);
    check("wrap_tag", ck_tag, 1);
    restore(2); step();
    check("mid_q", q0, 12);
    check("mid_tag", ck_tag, 2);
    check("mid_full", ck_full, 0);
    restore(3); ren(7, 5); step();
    check("badrest_q", q0, 5);
    check("badrest_tag", ck_tag, 2);
    rd(3, 4); rdy = 0; ren(3, 8); cm(0, 4, 0, 32'h99); ck_save = 1; step();
    check("hold_q", q0, 0);
    check("hold_v", v1, 0);
    check("hold_tag", ck_tag, 2);
    ren(3, 1); step();
    check("x3_q", q0, 1);
    flush = 1; cm(0, 3, 1, 32'h5); ren(8, 2); ck_save = 1; step();
    check("flush_q", q0, 0);
    check("flush_v", v0, 32'h5);
    check("flush_tag", ck_tag, 0);
    check("flush_full", ck_full, 0);
    rd(7, 8); #1;
    check("flush_x7", q0, 0);
    check("flush_x8", q1, 0);
    rd(9, 3); ren(9, 3); step();
    check("pre_rst_q", q0, 3);
    check("pre_rst_v", v1, 32'h5);
    #1 rst = 1;
    #1;
    check("arst_q", q0, 0);
    check("arst_v", v1, 0);
    #1 rst = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
